// File: rtl/seq11011_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq11011_tx
// Brief    : Serial frame transmitter: 11011 sync, zero-stuffed MSB-first
//            payload, then a forced run of guard zeros.
// Revision : 1.0
// ============================================================================
module seq11011_tx #(
    parameter int DATA_W = 8,
    parameter int GUARD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              tx_frame,
    output logic              tx_stuff
);

    localparam int CNT_MAX = (DATA_W > GUARD) ? ((DATA_W > 5) ? DATA_W : 5)
                                              : ((GUARD  > 5) ? GUARD  : 5);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [4:0]       c_SYNC       = 5'b11011;
    localparam logic [3:0]       c_STUFF_HIST = 4'b1101;
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_SYNC_LAST  = CNT_W'(4);
    localparam logic [CNT_W-1:0] c_DATA_LEN   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] c_GUARD_LAST = CNT_W'(GUARD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_DATA  = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [DATA_W-1:0] r_shift,  w_shift_nxt;
    logic [3:0]        r_hist,   w_hist_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic              r_tx,     w_tx_nxt;
    logic              r_frame,  w_frame_nxt;
    logic              r_stuff,  w_stuff_nxt;
    logic [2:0]        w_sync_idx;
    logic              w_sync_bit;

    assign in_ready = (r_state == S_IDLE);
    assign tx       = r_tx;
    assign tx_frame = r_frame;
    assign tx_stuff = r_stuff;

    // In SYNC the counter holds the index of the next sync bit (1..4).
    assign w_sync_idx = 3'd4 - r_cnt[2:0];
    assign w_sync_bit = c_SYNC[w_sync_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_hist_nxt  = r_hist;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = 1'b0;
        w_frame_nxt = 1'b0;
        w_stuff_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hist_nxt = 4'b0000;
                if (in_valid) begin
                    w_shift_nxt = in_data;
                    w_tx_nxt    = c_SYNC[4];
                    w_frame_nxt = 1'b1;
                    w_hist_nxt  = {3'b000, c_SYNC[4]};
                    w_cnt_nxt   = c_ONE;
                    w_state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                w_tx_nxt    = w_sync_bit;
                w_frame_nxt = 1'b1;
                w_hist_nxt  = {r_hist[2:0], w_sync_bit};
                if (r_cnt == c_SYNC_LAST) begin
                    w_cnt_nxt   = c_DATA_LEN;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            S_DATA: begin
                w_frame_nxt = 1'b1;
                // A 1 after history 1101 would complete 11011, so insert a 0 instead.
                if (r_hist == c_STUFF_HIST) begin
                    w_stuff_nxt = 1'b1;
                    w_hist_nxt  = {r_hist[2:0], 1'b0};
                end else begin
                    w_tx_nxt    = r_shift[DATA_W-1];
                    w_hist_nxt  = {r_hist[2:0], r_shift[DATA_W-1]};
                    w_shift_nxt = r_shift << 1;
                    w_cnt_nxt   = r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        w_cnt_nxt   = c_GUARD_LAST;
                        w_state_nxt = S_GUARD;
                    end
                end
            end
            S_GUARD: begin
                w_hist_nxt = 4'b0000;
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_hist  <= 4'b0000;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_frame <= 1'b0;
            r_stuff <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_hist  <= w_hist_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tx    <= w_tx_nxt;
            r_frame <= w_frame_nxt;
            r_stuff <= w_stuff_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq11011_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq11011_tx
// Brief    : Scoreboard bench for seq11011_tx with directed and random words.
// Revision : 1.0
// ============================================================================
module tb_seq11011_tx;

    localparam int DATA_W = 8;
    localparam int GUARD  = 2;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              tx;
    logic              tx_frame;
    logic              tx_stuff;

    seq11011_tx #(.DATA_W(DATA_W), .GUARD(GUARD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .tx_frame (tx_frame),
        .tx_stuff (tx_stuff)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bits;
        logic [63:0] stf;
        int          len;
        int          gap;
        bit          gap_valid;
    } frame_t;

    frame_t exp_q[$];
    int     n_chk  = 0;
    int     n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Expected frame: sync, then payload MSB first; a 0 is inserted whenever
    // the last four emitted bits are 1,1,0,1 and another payload bit follows.
    function automatic frame_t build(input logic [DATA_W-1:0] w);
        frame_t f;
        bit     e[$];
        bit     s[$];
        int     n;
        e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = DATA_W - 1; i >= 0; i--) begin
            n = e.size();
            if (e[n-4] && e[n-3] && !e[n-2] && e[n-1]) begin
                e.push_back(1'b0);
                s.push_back(1'b1);
            end
            e.push_back(w[i]);
            s.push_back(1'b0);
        end
        f.bits = '0;
        f.stf  = '0;
        f.len  = e.size();
        for (int k = 0; k < e.size(); k++) begin
            f.bits[k] = e[k];
            f.stf[k]  = s[k];
        end
        f.gap       = 0;
        f.gap_valid = 1'b0;
        return f;
    endfunction

    // Model: expected ready, acceptances and inter-frame idle time.
    int     busy       = 0;
    int     idle_edges = 0;
    int     acc_count  = 0;
    bit     exp_ready  = 1'b1;
    bit     in_reset   = 1'b1;
    bit     have_prev  = 1'b0;
    frame_t mf;

    always @(posedge clk) begin
        if (!rst) begin
            in_reset   = 1'b1;
            exp_q.delete();
            busy       = 0;
            idle_edges = 0;
            have_prev  = 1'b0;
        end else begin
            in_reset = 1'b0;
            if (busy == 0 && in_valid) begin
                mf           = build(in_data);
                mf.gap       = GUARD + idle_edges;
                mf.gap_valid = have_prev;
                exp_q.push_back(mf);
                busy       = mf.len + GUARD - 1;
                idle_edges = 0;
                have_prev  = 1'b1;
                acc_count++;
            end else if (busy == 0) begin
                idle_edges++;
            end else begin
                busy--;
            end
        end
        exp_ready = (busy == 0);
    end

    // Monitor: collects frames off the line and checks against the queue.
    logic [63:0] cur_bits    = '0;
    logic [63:0] cur_stf     = '0;
    int          cur_len     = 0;
    bit          cur_unexp   = 1'b0;
    int          gap_cnt     = 0;
    logic [4:0]  win         = '0;
    int          det_count   = 0;
    int          frames_done = 0;
    logic [63:0] last_bits   = '0;
    logic [63:0] last_stf    = '0;
    int          last_len    = 0;
    frame_t      ef;

    always @(negedge clk) begin
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        if (in_reset) begin
            check("reset_outputs", {61'd0, tx, tx_frame, tx_stuff}, 64'd0);
            cur_len = 0;
            gap_cnt = 0;
            win     = '0;
        end else begin
            win = {win[3:0], tx};
            if (tx_frame === 1'b1) begin
                if (cur_len == 0) begin
                    cur_bits  = '0;
                    cur_stf   = '0;
                    cur_unexp = (exp_q.size() == 0);
                    if (cur_unexp) begin
                        timeout("unexpected_frame");
                    end else if (exp_q[0].gap_valid) begin
                        check("gap_zeros", 64'(gap_cnt), 64'(exp_q[0].gap));
                    end
                end
                if (cur_len < 64) begin
                    cur_bits[cur_len] = tx;
                    cur_stf[cur_len]  = tx_stuff;
                end
                cur_len++;
            end else begin
                check("idle_line", {62'd0, tx, tx_stuff}, 64'd0);
                if (cur_len != 0) begin
                    last_bits = cur_bits;
                    last_stf  = cur_stf;
                    last_len  = cur_len;
                    frames_done++;
                    if (!cur_unexp) begin
                        ef = exp_q.pop_front();
                        check("frame_len",  64'(cur_len), 64'(ef.len));
                        check("frame_bits", cur_bits, ef.bits);
                        check("frame_stuff", cur_stf, ef.stf);
                    end
                    cur_len = 0;
                    gap_cnt = 0;
                end
                gap_cnt++;
            end
            check("detector", {63'd0, (win == 5'b11011)},
                  {63'd0, (tx_frame === 1'b1 && cur_len == 5)});
            if (win == 5'b11011) det_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int a0;
        bit ok;
        a0 = acc_count;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (acc_count != a0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("accept");
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (exp_ready && exp_q.size() == 0 && cur_len == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout("idle");
    endtask

    int d0;
    int f0;

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        check("ready_after_reset", {63'd0, in_ready}, 64'd1);
        check("tx_after_reset", {63'd0, tx}, 64'd0);

        // 0x00: plain sync then eight zeros
        send_word(8'h00);
        wait_idle();
        check("len_00",  64'(last_len), 64'd13);
        check("bits_00", last_bits, 64'h1B);
        check("stuff_00", last_stf, 64'h0);

        // 0xFF: no stuffing ever triggers
        send_word(8'hFF);
        wait_idle();
        check("len_FF",  64'(last_len), 64'd13);
        check("bits_FF", last_bits, 64'h1FFB);
        check("stuff_FF", last_stf, 64'h0);

        // 0x6D: one stuff bit in the 8th frame cycle
        d0 = det_count;
        send_word(8'h6D);
        wait_idle();
        check("len_6D",  64'(last_len), 64'd14);
        check("bits_6D", last_bits, 64'h2D5B);
        check("stuff_6D", last_stf, 64'h80);
        check("det_6D", 64'(det_count - d0), 64'd1);

        // Back-to-back with valid held high
        d0 = det_count;
        f0 = frames_done;
        in_data  = 8'hB6;
        in_valid = 1'b1;
        wait_accept();
        in_data = 8'hDB;
        wait_accept();
        in_valid = 1'b0;
        wait_idle();
        check("det_b2b", 64'(det_count - d0), 64'd2);
        check("frames_b2b", 64'(frames_done - f0), 64'd2);

        // Reset during the 3rd payload bit
        send_word(8'h00);
        repeat (7) tick();
        check("mid_frame_active", {63'd0, tx_frame}, 64'd1);
        rst = 1'b0;
        tick();
        check("abort_outputs", {61'd0, tx, tx_frame, tx_stuff}, 64'd0);
        rst = 1'b1;
        tick();
        check("ready_after_abort", {63'd0, in_ready}, 64'd1);
        send_word(8'h00);
        wait_idle();
        check("len_after_abort",  64'(last_len), 64'd13);
        check("bits_after_abort", last_bits, 64'h1B);

        // Valid toggling while busy must not be accepted
        f0 = frames_done;
        send_word(8'hA5);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (exp_ready) break;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DATA_W'($urandom);
        end
        in_valid = 1'b0;
        wait_idle();
        check("frames_busy", 64'(frames_done - f0), 64'd1);

        // Random traffic with one reset in the middle
        for (int k = 0; k < 900; k++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = DATA_W'($urandom);
            rst      = !(k >= 450 && k < 452);
            tick();
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
